// File: rtl/btle_phy_arb_pkg.sv
// btle_phy_arb_pkg: shared FSM states, completion codes and op encodings for the PHY arbiter
package btle_phy_arb_pkg;
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GRANT,
      ST_TX_START,
      ST_TX_WAIT,
      ST_RX_WAIT,
      ST_DONE
   } arb_state_t;
   localparam logic [1:0] DS_TX_OK   = 2'b00;
   localparam logic [1:0] DS_RX_OK   = 2'b01;
   localparam logic [1:0] DS_RX_FAIL = 2'b10;
   localparam logic [1:0] DS_TIMEOUT = 2'b11;
   localparam logic OP_TX = 1'b0;
   localparam logic OP_RX = 1'b1;
endpackage

// File: rtl/btle_rr_arbiter.sv
// btle_rr_arbiter: picks the winning requester, fixed priority from 0 or round-robin from a pointer
module btle_rr_arbiter #(
   parameter int N_SRC = 3,
   localparam int IW = (N_SRC > 2) ? $clog2(N_SRC) : 1
) (
   input  logic             rr_mode,
   input  logic [N_SRC-1:0] req,
   input  logic [IW-1:0]    ptr,
   output logic [IW-1:0]    winner,
   output logic             valid
);
   logic [IW-1:0]    start;
   logic [N_SRC-1:0] rot;
   logic [IW:0]      sum;
   // rotate requests so the search origin sits at bit 0, take the lowest set bit, then undo the rotation
   always_comb begin
      start = rr_mode ? ptr : '0;
      rot = N_SRC'({req, req} >> start);
      valid = 1'b0;
      sum = '0;
      for (int i = N_SRC - 1; i >= 0; i--)
         if (rot[i]) begin
            sum = {1'b0, start} + (IW+1)'(i);
            valid = 1'b1;
         end
      winner = IW'((sum >= (IW+1)'(N_SRC)) ? sum - (IW+1)'(N_SRC) : sum);
   end
endmodule

// File: rtl/btle_phy_arbiter.sv
// btle_phy_arbiter: shares one BTLE PHY between N_SRC requesters, sequencing TX/RX ops under a watchdog
module btle_phy_arbiter
   import btle_phy_arb_pkg::*;
#(
   parameter int N_SRC = 3,
   parameter int CFG_W = 128,
   parameter int TIMEOUT_W = 16,
   parameter int ARB_MODE = 0,
   localparam int OW = (N_SRC > 2) ? $clog2(N_SRC) : 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_SRC-1:0]       src_req,
   input  logic [N_SRC-1:0]       src_op,
   input  logic [N_SRC*CFG_W-1:0] src_cfg,
   output logic [N_SRC-1:0]       src_grant,
   output logic [N_SRC-1:0]       src_done,
   output logic [1:0]             done_status,
   input  logic [TIMEOUT_W-1:0]   timeout_cycles,
   output logic [CFG_W-1:0]       phy_cfg,
   output logic                   phy_tx_start,
   output logic                   phy_rx_en,
   input  logic                   phy_tx_done,
   input  logic                   phy_rx_decode_end,
   input  logic                   phy_rx_crc_ok,
   output logic                   busy,
   output logic [OW-1:0]          owner
);
   arb_state_t           state;
   logic                 op_q;
   logic [OW-1:0]        rr_ptr;
   logic [OW-1:0]        winner;
   logic                 arb_valid;
   logic [TIMEOUT_W-1:0] wd;
   logic [TIMEOUT_W-1:0] wd_next;
   logic                 fin;
   logic [1:0]           fin_status;
   logic [CFG_W-1:0]     cfg_arr [N_SRC];

   for (genvar g = 0; g < N_SRC; g++) begin : g_cfg
      assign cfg_arr[g] = src_cfg[g*CFG_W +: CFG_W];
   end

   btle_rr_arbiter #(.N_SRC(N_SRC)) u_arb (
      .rr_mode (ARB_MODE != 0),
      .req     (src_req),
      .ptr     (rr_ptr),
      .winner  (winner),
      .valid   (arb_valid)
   );

   // wait-state exit decision: a PHY completion beats a watchdog expiry landing in the same cycle
   always_comb begin
      wd_next = wd + 1'b1;
      fin = 1'b0;
      fin_status = DS_TIMEOUT;
      if (state == ST_TX_WAIT && phy_tx_done) begin
         fin = 1'b1;
         fin_status = DS_TX_OK;
      end else if (state == ST_RX_WAIT && phy_rx_decode_end) begin
         fin = 1'b1;
         fin_status = phy_rx_crc_ok ? DS_RX_OK : DS_RX_FAIL;
      end else if ((state == ST_TX_WAIT || state == ST_RX_WAIT) && timeout_cycles != '0 && wd_next == timeout_cycles)
         fin = 1'b1;
   end

   // operation sequencer; every output is a register updated here
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         src_grant    <= '0;
         src_done     <= '0;
         done_status  <= DS_TX_OK;
         phy_cfg      <= '0;
         phy_tx_start <= 1'b0;
         phy_rx_en    <= 1'b0;
         busy         <= 1'b0;
         owner        <= '0;
         op_q         <= OP_TX;
         rr_ptr       <= '0;
         wd           <= '0;
      end else begin
         src_done     <= '0;
         phy_tx_start <= 1'b0;
         case (state)
            ST_IDLE:
               if (arb_valid) begin
                  state     <= ST_GRANT;
                  owner     <= winner;
                  src_grant <= N_SRC'(1) << winner;
                  phy_cfg   <= cfg_arr[winner];
                  op_q      <= src_op[winner];
                  busy      <= 1'b1;
                  rr_ptr    <= (winner == OW'(N_SRC - 1)) ? '0 : winner + 1'b1;
               end
            ST_GRANT: begin
               state        <= (op_q == OP_TX) ? ST_TX_START : ST_RX_WAIT;
               phy_tx_start <= (op_q == OP_TX);
               phy_rx_en    <= (op_q == OP_RX);
               wd           <= '0;
            end
            ST_TX_START: begin
               state <= ST_TX_WAIT;
               wd    <= '0;
            end
            ST_TX_WAIT, ST_RX_WAIT:
               if (fin) begin
                  state       <= ST_DONE;
                  src_done    <= src_grant;
                  done_status <= fin_status;
                  phy_rx_en   <= 1'b0;
               end else
                  wd <= wd_next;
            ST_DONE: begin
               state     <= ST_IDLE;
               src_grant <= '0;
               busy      <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_btle_phy_arbiter.sv
// tb_btle_phy_arbiter: fixed-priority and round-robin instances checked against a transaction-level model
module tb_btle_phy_arbiter;
   localparam int N  = 3;
   localparam int CW = 128;
   localparam int TW = 16;

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic [N-1:0]    src_req = '0;
   logic [N-1:0]    src_op = '0;
   logic [N*CW-1:0] src_cfg = '0;
   logic [TW-1:0]   timeout_cycles = '0;
   logic            phy_tx_done = 1'b0;
   logic            phy_rx_decode_end = 1'b0;
   logic            phy_rx_crc_ok = 1'b0;

   logic [N-1:0]    grant_o [2];
   logic [N-1:0]    done_o [2];
   logic [1:0]      status_o [2];
   logic [CW-1:0]   cfg_o [2];
   logic            tx_start_o [2];
   logic            rx_en_o [2];
   logic            busy_o [2];
   logic [1:0]      owner_o [2];

   int n_chk = 0;
   int n_fail = 0;

   // model: per instance, whether an op is in progress, its owner/op/config, cycles since grant,
   // whether this is the completion cycle, last status and round-robin origin
   bit            m_busy [2];
   bit            m_op [2];
   bit            m_fin [2];
   int            m_owner [2];
   int            m_age [2];
   int            m_status [2];
   int            m_ptr [2];
   logic [CW-1:0] m_cfg [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      btle_phy_arbiter #(.N_SRC(N), .CFG_W(CW), .TIMEOUT_W(TW), .ARB_MODE(g)) u_dut (
         .clk               (clk),
         .rst_n             (rst_n),
         .src_req           (src_req),
         .src_op            (src_op),
         .src_cfg           (src_cfg),
         .src_grant         (grant_o[g]),
         .src_done          (done_o[g]),
         .done_status       (status_o[g]),
         .timeout_cycles    (timeout_cycles),
         .phy_cfg           (cfg_o[g]),
         .phy_tx_start      (tx_start_o[g]),
         .phy_rx_en         (rx_en_o[g]),
         .phy_tx_done       (phy_tx_done),
         .phy_rx_decode_end (phy_rx_decode_end),
         .phy_rx_crc_ok     (phy_rx_crc_ok),
         .busy              (busy_o[g]),
         .owner             (owner_o[g])
      );
   end

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL sim_timeout: run still going at %0t, expected finish", $time);
      $fatal(1, "simulation time limit");
   end

   task automatic chk(string name, int u, logic [CW-1:0] act, logic [CW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[u%0d] @%0t: got %0h expected %0h", name, u, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int u = 0; u < 2; u++) begin
         m_busy[u] = 0; m_op[u] = 0; m_fin[u] = 0; m_owner[u] = 0;
         m_age[u] = 0; m_status[u] = 0; m_ptr[u] = 0; m_cfg[u] = '0;
      end
   endtask

   task automatic model_step();
      int w;
      int ws;
      int idx;
      logic [N-1:0] t;
      logic ev;
      for (int u = 0; u < 2; u++) begin
         if (!m_busy[u]) begin
            w = -1;
            for (int k = N - 1; k >= 0; k--) begin
               idx = ((u == 1 ? m_ptr[u] : 0) + k) % N;
               t = src_req >> idx;
               if (t[0]) w = idx;
            end
            if (w >= 0) begin
               m_busy[u] = 1;
               m_owner[u] = w;
               t = src_op >> w;
               m_op[u] = t[0];
               m_cfg[u] = CW'(src_cfg >> (w * CW));
               m_age[u] = 0;
               m_fin[u] = 0;
               m_ptr[u] = (w + 1) % N;
            end
         end else if (m_fin[u]) begin
            m_busy[u] = 0;
            m_fin[u] = 0;
         end else begin
            ws = m_op[u] ? 1 : 2;
            if (m_age[u] >= ws) begin
               ev = m_op[u] ? phy_rx_decode_end : phy_tx_done;
               if (ev) begin
                  m_fin[u] = 1;
                  m_status[u] = m_op[u] ? (phy_rx_crc_ok ? 1 : 2) : 0;
               end else if (timeout_cycles != 0 && m_age[u] - ws + 1 == int'(timeout_cycles)) begin
                  m_fin[u] = 1;
                  m_status[u] = 3;
               end
            end
            m_age[u]++;
         end
      end
   endtask

   task automatic compare_all();
      for (int u = 0; u < 2; u++) begin
         chk("grant", u, CW'(grant_o[u]), m_busy[u] ? CW'(1) << m_owner[u] : '0);
         chk("done", u, CW'(done_o[u]), m_fin[u] ? CW'(1) << m_owner[u] : '0);
         chk("status", u, CW'(status_o[u]), CW'(m_status[u]));
         chk("phy_cfg", u, cfg_o[u], m_cfg[u]);
         chk("tx_start", u, CW'(tx_start_o[u]), CW'(m_busy[u] && !m_op[u] && m_age[u] == 1 && !m_fin[u]));
         chk("rx_en", u, CW'(rx_en_o[u]), CW'(m_busy[u] && m_op[u] && m_age[u] >= 1 && !m_fin[u]));
         chk("busy", u, CW'(busy_o[u]), CW'(m_busy[u]));
         chk("owner", u, CW'(owner_o[u]), CW'(m_owner[u]));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_step();
      @(negedge clk);
      compare_all();
   endtask

   task automatic ticks(int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic zero_checks(string tag);
      for (int u = 0; u < 2; u++) begin
         chk({tag, "_grant"}, u, CW'(grant_o[u]), '0);
         chk({tag, "_done"}, u, CW'(done_o[u]), '0);
         chk({tag, "_status"}, u, CW'(status_o[u]), '0);
         chk({tag, "_cfg"}, u, cfg_o[u], '0);
         chk({tag, "_tx_start"}, u, CW'(tx_start_o[u]), '0);
         chk({tag, "_rx_en"}, u, CW'(rx_en_o[u]), '0);
         chk({tag, "_busy"}, u, CW'(busy_o[u]), '0);
         chk({tag, "_owner"}, u, CW'(owner_o[u]), '0);
      end
   endtask

   task automatic do_reset(string tag);
      rst_n = 1'b0;
      model_reset();
      phy_tx_done = 1'b0;
      phy_rx_decode_end = 1'b0;
      #1 zero_checks(tag);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic rand_cfg();
      for (int i = 0; i < N * CW / 32; i++) src_cfg[i*32 +: 32] = $urandom;
   endtask

   typedef struct {
      logic [N-1:0] req;
      logic [N-1:0] op;
      logic         crc;
      logic [N-1:0] grant;
      logic         rx;
      logic [1:0]   status;
   } vec_t;

   vec_t tbl [6];
   int   exp_rr [4];
   int   bad;

   initial begin
      tbl[0] = '{3'b110, 3'b000, 1'b0, 3'b010, 1'b0, 2'b00};
      tbl[1] = '{3'b001, 3'b001, 1'b1, 3'b001, 1'b1, 2'b01};
      tbl[2] = '{3'b111, 3'b110, 1'b0, 3'b001, 1'b0, 2'b00};
      tbl[3] = '{3'b100, 3'b100, 1'b0, 3'b100, 1'b1, 2'b10};
      tbl[4] = '{3'b101, 3'b001, 1'b0, 3'b001, 1'b1, 2'b10};
      tbl[5] = '{3'b010, 3'b010, 1'b1, 3'b010, 1'b1, 2'b01};
      exp_rr = '{0, 1, 2, 0};

      #1 do_reset("por");

      // single operations from a fresh reset; both instances agree since the pointer starts at 0
      for (int v = 0; v < 6; v++) begin
         #2 do_reset("vec_rst");
         rand_cfg();
         src_req = tbl[v].req;
         src_op = tbl[v].op;
         tick();
         for (int u = 0; u < 2; u++) chk("vec_grant", u, CW'(grant_o[u]), CW'(tbl[v].grant));
         src_req = '0;
         src_op = ~src_op;
         rand_cfg();
         tick();
         for (int u = 0; u < 2; u++) begin
            chk("vec_tx_start", u, CW'(tx_start_o[u]), CW'(!tbl[v].rx));
            chk("vec_rx_en", u, CW'(rx_en_o[u]), CW'(tbl[v].rx));
         end
         if (!tbl[v].rx) tick();
         phy_tx_done = 1'b1;
         phy_rx_decode_end = 1'b1;
         phy_rx_crc_ok = tbl[v].crc;
         tick();
         phy_tx_done = 1'b0;
         phy_rx_decode_end = 1'b0;
         for (int u = 0; u < 2; u++) begin
            chk("vec_done", u, CW'(done_o[u]), CW'(tbl[v].grant));
            chk("vec_status", u, CW'(status_o[u]), CW'(tbl[v].status));
         end
         tick();
         for (int u = 0; u < 2; u++) chk("vec_idle", u, CW'(busy_o[u]), '0);
      end

      // round-robin with every request held: owners rotate 0,1,2,0
      #2 do_reset("rr_rst");
      src_req = 3'b111;
      src_op = 3'b000;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("rr_owner", 1, CW'(owner_o[1]), CW'(exp_rr[k]));
         chk("fixed_owner", 0, CW'(owner_o[0]), '0);
         ticks(2);
         phy_tx_done = 1'b1;
         tick();
         phy_tx_done = 1'b0;
         tick();
      end
      src_req = '0;

      // RX with CRC failure on wait cycle 5
      #2 do_reset("rx_rst");
      timeout_cycles = 16'd20;
      src_req = 3'b001;
      src_op = 3'b001;
      tick();
      src_req = '0;
      tick();
      chk("rx_en_wait", 0, CW'(rx_en_o[0]), 1);
      ticks(5);
      phy_rx_decode_end = 1'b1;
      phy_rx_crc_ok = 1'b0;
      tick();
      phy_rx_decode_end = 1'b0;
      chk("rx_fail_done", 0, CW'(done_o[0]), CW'(3'b001));
      chk("rx_fail_status", 0, CW'(status_o[0]), CW'(2'b10));
      chk("rx_en_done", 0, CW'(rx_en_o[0]), '0);
      tick();
      chk("rx_en_after", 0, CW'(rx_en_o[0]), '0);

      // watchdog expiry after 10 wait cycles, then a decode_end on the same last cycle
      for (int pass = 0; pass < 2; pass++) begin
         timeout_cycles = 16'd10;
         src_req = 3'b100;
         src_op = 3'b100;
         tick();
         src_req = '0;
         ticks(10);
         chk("wd_pre_busy", 0, CW'(busy_o[0]), 1);
         chk("wd_pre_done", 0, CW'(done_o[0]), '0);
         phy_rx_decode_end = (pass == 1);
         phy_rx_crc_ok = 1'b1;
         tick();
         phy_rx_decode_end = 1'b0;
         chk("wd_done", 0, CW'(done_o[0]), CW'(3'b100));
         chk("wd_status", 0, CW'(status_o[0]), pass == 1 ? CW'(2'b01) : CW'(2'b11));
         tick();
      end

      // reset in the middle of a TX wait, then a normal TX
      #2 do_reset("mid_pre");
      timeout_cycles = '0;
      src_req = 3'b010;
      src_op = 3'b000;
      tick();
      src_req = '0;
      ticks(4);
      chk("mid_busy", 0, CW'(busy_o[0]), 1);
      #2 do_reset("mid_rst");
      for (int u = 0; u < 2; u++) chk("mid_no_done", u, CW'(done_o[u]), '0);
      src_req = 3'b010;
      tick();
      chk("mid_regrant", 0, CW'(grant_o[0]), CW'(3'b010));
      src_req = '0;
      tick();
      chk("mid_tx_start", 0, CW'(tx_start_o[0]), 1);
      tick();
      phy_tx_done = 1'b1;
      tick();
      phy_tx_done = 1'b0;
      chk("mid_done", 0, CW'(done_o[0]), CW'(3'b010));
      chk("mid_status", 0, CW'(status_o[0]), '0);
      tick();

      // watchdog disabled: a TX that never completes stays busy with no done pulse
      timeout_cycles = '0;
      src_req = 3'b010;
      src_op = 3'b000;
      tick();
      src_req = '0;
      bad = 0;
      for (int i = 0; i < 70000; i++) begin
         tick();
         for (int u = 0; u < 2; u++) if (busy_o[u] !== 1'b1 || done_o[u] !== '0) bad++;
      end
      chk("long_busy", 0, CW'(bad), '0);
      phy_tx_done = 1'b1;
      tick();
      phy_tx_done = 1'b0;
      chk("long_done", 0, CW'(done_o[0]), CW'(3'b010));
      tick();

      // randomized traffic against the model, several watchdog limits
      for (int b = 0; b < 4; b++) begin
         timeout_cycles = TW'(b == 0 ? 0 : b * 8 - 4);
         for (int i = 0; i < 500; i++) begin
            src_req = N'($urandom_range(0, 7));
            src_op = N'($urandom_range(0, 7));
            if ((i % 8) == 0) rand_cfg();
            phy_tx_done = ($urandom_range(0, 7) == 0);
            phy_rx_decode_end = ($urandom_range(0, 7) == 0);
            phy_rx_crc_ok = $urandom_range(0, 1) == 1;
            tick();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
